// File: rtl/temporal_encoder_if.sv
// Input-side valid/ready channel of the temporal encoder: one NCH*W-bit vector per transfer.
interface temporal_encoder_if #(
  parameter int unsigned NCH = 2,
  parameter int unsigned W   = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [NCH*W-1:0] in_value;

  modport master (output in_valid, output in_value, input in_ready);
  modport slave  (input in_valid, input in_value, output in_ready);
endinterface

// File: rtl/temporal_encoder.sv
// Binary-to-race-logic encoder: replays a latched vector as one gamma window of edge-coded and
// pulse-width-coded signals, followed by a clear phase at the idle level.
module temporal_encoder #(
  parameter int unsigned NCH        = 2,
  parameter int unsigned W          = 4,
  parameter int unsigned GAMMA      = 16,
  parameter int unsigned CLR_CYCLES = 2,
  parameter bit          FALLING    = 1'b0
) (
  input  logic                aclk,
  input  logic                grst,
  temporal_encoder_if.slave   in_bus,
  output logic [NCH-1:0]      edge_o,
  output logic [NCH-1:0]      pulse_o,
  output logic                win_start,
  output logic                win_done,
  output logic                busy
);

  localparam int unsigned      CW       = $clog2(GAMMA) + 1;
  localparam logic [W-1:0]     INF      = '1;
  localparam logic [NCH-1:0]   IDLE_LVL = {NCH{FALLING}};
  localparam logic [CW-1:0]    T_LAST   = CW'(GAMMA - 1);
  localparam logic [CW-1:0]    C_LAST   = CW'(CLR_CYCLES - 1);

  if (GAMMA < (2 ** W) - 1) begin : g_gamma_check
    $error("temporal_encoder: GAMMA must be >= 2**W-1");
  end
  if (CLR_CYCLES < 1 || CLR_CYCLES > (2 ** CW)) begin : g_clr_check
    $error("temporal_encoder: CLR_CYCLES must be >= 1 and fit the window counter");
  end

  typedef enum logic [1:0] {StIdle, StRun, StClear} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [NCH*W-1:0] val_q, val_d;
  logic [NCH-1:0]   edge_q, edge_d, pulse_q, pulse_d;
  logic             ready_q, ready_d, start_q, start_d, done_q, done_d, busy_q, busy_d;
  logic             accept;

  // Active-high levels for window cycle t; polarity is applied before the output register.
  function automatic logic [NCH-1:0] edge_act(logic [CW-1:0] t, logic [NCH*W-1:0] v);
    for (int i = 0; i < NCH; i++) begin
      edge_act[i] = (v[i*W +: W] != INF) && (32'(t) >= 32'(v[i*W +: W]));
    end
  endfunction

  function automatic logic [NCH-1:0] pulse_act(logic [CW-1:0] t, logic [NCH*W-1:0] v);
    for (int i = 0; i < NCH; i++) begin
      pulse_act[i] = (v[i*W +: W] == INF) || (32'(t) < 32'(v[i*W +: W]));
    end
  endfunction

  assign accept  = in_bus.in_valid && ready_q;
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    ready_d = 1'b0;
    start_d = 1'b0;
    done_d  = 1'b0;
    busy_d  = 1'b0;
    edge_d  = IDLE_LVL;
    pulse_d = IDLE_LVL;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StRun;
          cnt_d   = '0;
          val_d   = in_bus.in_value;
          busy_d  = 1'b1;
          start_d = 1'b1;
          done_d  = (T_LAST == '0);
          edge_d  = edge_act('0, in_bus.in_value) ^ IDLE_LVL;
          pulse_d = pulse_act('0, in_bus.in_value) ^ IDLE_LVL;
        end else begin
          ready_d = 1'b1;
        end
      end
      StRun: begin
        busy_d = 1'b1;
        if (cnt_q == T_LAST) begin
          state_d = StClear;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_inc;
          done_d  = (cnt_inc == T_LAST);
          edge_d  = edge_act(cnt_inc, val_q) ^ IDLE_LVL;
          pulse_d = pulse_act(cnt_inc, val_q) ^ IDLE_LVL;
        end
      end
      StClear: begin
        if (cnt_q == C_LAST) begin
          state_d = StIdle;
          cnt_d   = '0;
          ready_d = 1'b1;
        end else begin
          cnt_d  = cnt_inc;
          busy_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge grst) begin
    if (!grst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      val_q   <= {NCH{INF}};
      edge_q  <= IDLE_LVL;
      pulse_q <= IDLE_LVL;
      ready_q <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      edge_q  <= edge_d;
      pulse_q <= pulse_d;
      ready_q <= ready_d;
      start_q <= start_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign in_bus.in_ready = ready_q;
  assign edge_o          = edge_q;
  assign pulse_o         = pulse_q;
  assign win_start       = start_q;
  assign win_done        = done_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_temporal_encoder.sv
// Scoreboard bench: a rising-polarity and a falling-polarity encoder share one random stimulus
// stream; a monitor replays each accepted vector through a window-level reference model.
module tb_temporal_encoder;
  localparam int unsigned NCH     = 2;
  localparam int unsigned W       = 4;
  localparam int unsigned GAMMA   = 16;
  localparam int unsigned CLR     = 2;
  localparam int          INF     = 15;
  localparam int          SPACING = GAMMA + CLR + 1;
  localparam int          TW      = 4 * NCH + 8;
  localparam logic [TW-1:0] IDLE_MASK = {{(4 * NCH){1'b1}}, 8'b0110_0110};

  typedef struct {
    logic [NCH*W-1:0] val;
    int               acc;
  } exp_t;

  logic aclk = 1'b0;
  logic grst = 1'b0;
  logic drv_valid = 1'b0;
  logic [NCH*W-1:0] drv_value = '0;
  logic [NCH-1:0] edge_r, pulse_r, edge_f, pulse_f;
  logic ws_r, wd_r, busy_r, ws_f, wd_f, busy_f;

  exp_t sb[$];
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int mon_t = -1;
  logic [NCH*W-1:0] cur_v;

  initial forever #5 aclk = ~aclk;
  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  temporal_encoder_if #(.NCH(NCH), .W(W)) bus_r ();
  temporal_encoder_if #(.NCH(NCH), .W(W)) bus_f ();
  assign bus_r.in_valid = drv_valid;
  assign bus_r.in_value = drv_value;
  assign bus_f.in_valid = drv_valid;
  assign bus_f.in_value = drv_value;

  temporal_encoder #(.NCH(NCH), .W(W), .GAMMA(GAMMA), .CLR_CYCLES(CLR), .FALLING(1'b0)) dut_r (
    .aclk(aclk), .grst(grst), .in_bus(bus_r.slave), .edge_o(edge_r), .pulse_o(pulse_r),
    .win_start(ws_r), .win_done(wd_r), .busy(busy_r)
  );
  temporal_encoder #(.NCH(NCH), .W(W), .GAMMA(GAMMA), .CLR_CYCLES(CLR), .FALLING(1'b1)) dut_f (
    .aclk(aclk), .grst(grst), .in_bus(bus_f.slave), .edge_o(edge_f), .pulse_o(pulse_f),
    .win_start(ws_f), .win_done(wd_f), .busy(busy_f)
  );

  function automatic logic [TW-1:0] actual();
    return {edge_r, pulse_r, edge_f, pulse_f, ws_r, wd_r, busy_r, bus_r.in_ready,
            ws_f, wd_f, busy_f, bus_f.in_ready};
  endfunction

  // Both DUTs in one word: the falling instance must show the complemented event levels.
  function automatic logic [TW-1:0] pack(logic [NCH-1:0] e, logic [NCH-1:0] p, logic ws,
                                         logic wd, logic bz, logic rdy);
    return {e, p, ~e, ~p, ws, wd, bz, rdy, ws, wd, bz, rdy};
  endfunction

  // Window model: channel i fires at cycle v (never for INF); its pulse lasts v cycles (GAMMA for INF).
  function automatic logic [2*NCH-1:0] model(logic [NCH*W-1:0] v, int t);
    logic [NCH-1:0] e, p;
    for (int i = 0; i < NCH; i++) begin
      int vi, fire_at, width;
      vi      = int'(v[i*W +: W]);
      fire_at = (vi == INF) ? -1 : vi;
      width   = (vi == INF) ? GAMMA : vi;
      e[i]    = (fire_at >= 0) && (t >= fire_at);
      p[i]    = t < width;
    end
    return {e, p};
  endfunction

  task automatic check(input string name, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  // Monitor
  initial begin
    exp_t e;
    logic [2*NCH-1:0] m;
    forever begin
      @(negedge aclk);
      if (!grst) begin
        mon_t = -1;
        sb.delete();
      end else begin
        if (mon_t < 0) begin
          if (ws_r || ws_f) begin
            if (sb.size() == 0) begin
              fail("unexpected_start");
            end else begin
              e = sb.pop_front();
              cur_v = e.val;
              check_int("start_latency", cyc, e.acc + 1);
              mon_t = 0;
            end
          end else begin
            check("idle_levels", actual() & IDLE_MASK, pack('0, '0, 0, 0, 0, 0) & IDLE_MASK);
            if (sb.size() > 0 && cyc > sb[0].acc + 1) begin
              fail("start_timeout");
              void'(sb.pop_front());
            end
          end
        end
        if (mon_t >= 0) begin
          if (mon_t < GAMMA) begin
            m = model(cur_v, mon_t);
            check($sformatf("run_t%0d_v%h", mon_t, cur_v), actual(),
                  pack(m[2*NCH-1:NCH], m[NCH-1:0], mon_t == 0, mon_t == GAMMA - 1, 1'b1, 1'b0));
          end else if (mon_t < GAMMA + CLR) begin
            check("clear_phase", actual(), pack('0, '0, 0, 0, 1, 0));
          end else begin
            check("back_to_idle", actual(), pack('0, '0, 0, 0, 0, 1));
          end
          mon_t++;
          if (mon_t > GAMMA + CLR) mon_t = -1;
        end
      end
    end
  end

  task automatic send(input logic [NCH*W-1:0] val, output int acc);
    acc = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge aclk);
      drv_valid = 1'b1;
      drv_value = val;
      if (bus_r.in_ready) begin
        sb.push_back('{val: val, acc: cyc});
        acc = cyc;
        break;
      end
    end
    @(negedge aclk);
    drv_valid = 1'b0;
    drv_value = NCH*W'($urandom);
    if (acc < 0) fail("accept_timeout");
  endtask

  task automatic release_reset();
    #2 grst = 1'b1;
    #1 check_int("ready_low_after_release", {bus_r.in_ready, bus_f.in_ready}, 0);
    @(posedge aclk);
    #1 check_int("ready_high_one_edge_later", {bus_r.in_ready, bus_f.in_ready}, 3);
  endtask

  initial begin
    int acc, prev, got;
    logic [NCH*W-1:0] fixed_v[6];
    fixed_v = '{8'h73, 8'hF0, 8'h22, 8'h00, 8'hFF, 8'hE1};

    repeat (3) @(negedge aclk);
    check("reset_state", actual(), pack('0, '0, 0, 0, 0, 0));
    release_reset();

    foreach (fixed_v[k]) send(fixed_v[k], acc);
    for (int k = 0; k < 6; k++) send(NCH*W'($urandom), acc);

    // in_valid held high with in_value changing every cycle
    prev = -1;
    got = 0;
    for (int n = 0; n < 200 && got < 4; n++) begin
      @(negedge aclk);
      drv_valid = 1'b1;
      drv_value = NCH*W'($urandom);
      if (bus_r.in_ready) begin
        sb.push_back('{val: drv_value, acc: cyc});
        if (prev >= 0) check_int("accept_spacing", cyc - prev, SPACING);
        prev = cyc;
        got++;
      end
    end
    if (got < 4) fail("stream_accepts");
    @(negedge aclk);
    drv_valid = 1'b0;

    // Abandon a window at t=5
    send(8'h5A, acc);
    while (cyc < acc + 6) @(negedge aclk);
    #2 grst = 1'b0;
    #1 check("async_reset_mid_window", actual(), pack('0, '0, 0, 0, 0, 0));
    repeat (2) @(negedge aclk);
    check("reset_hold", actual(), pack('0, '0, 0, 0, 0, 0));
    release_reset();
    send(8'h22, acc);

    for (int n = 0; n < 100 && (sb.size() > 0 || mon_t >= 0); n++) @(negedge aclk);
    if (sb.size() > 0 || mon_t >= 0) fail("drain_timeout");
    repeat (3) @(negedge aclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/temporal_encoder.md
Name: temporal_encoder

Overview:
- Binary-to-race-logic encoder: the producer side of the temporal (edge/pulse-coded) signals consumed by min and related race-logic primitives.
- Accepts a vector of NCH binary values over a valid/ready handshake and replays it as one gamma window of GAMMA cycles.
- Each channel emits an edge-coded output (transition at cycle = value) and a pulse-width-coded output (width = value).
- After each window it drives all outputs to the idle level for CLR_CYCLES cycles, so downstream race logic resets before the next window.

Parameters:
- NCH, 2: number of channels.
- W, 4: value width per channel. The all-ones value (2^W-1) is INF, meaning "no event".
- GAMMA, 16: window length in cycles. Elaboration error if GAMMA < 2^W-1.
- CLR_CYCLES, 2: length of the clear phase. Must be >= 1; elaboration error otherwise.
- FALLING, 0: 0 = idle low, events are rising edges. 1 = idle high, events are falling edges and all edge_o/pulse_o levels are inverted.

Ports:
- aclk, in, 1: clock, rising-edge.
- grst, in, 1: reset, asynchronous assert, active-low.
- in_valid, in, 1: input vector valid.
- in_ready, out, 1: encoder can accept a vector (IDLE only).
- in_value, in, NCH*W: channel i occupies bits [i*W +: W].
- edge_o, out, NCH: edge-coded outputs.
- pulse_o, out, NCH: pulse-width-coded outputs.
- win_start, out, 1: one-cycle pulse in RUN t=0.
- win_done, out, 1: one-cycle pulse in RUN t=GAMMA-1.
- busy, out, 1: high in RUN and CLEAR.

Behaviour:
- All outputs are registered. In the levels below, "active" means 1 when FALLING=0 and 0 when FALLING=1; "idle" is the opposite.
- Reset (grst=0, asynchronous):
  - State goes to IDLE; counter = 0; latched values = INF.
  - edge_o and pulse_o = idle level; in_ready = 0; busy, win_start, win_done = 0.
  - in_ready rises on the first aclk edge after grst deasserts.
- States: IDLE -> RUN -> CLEAR -> IDLE.
- IDLE:
  - in_ready = 1; outputs at idle level.
  - On in_valid && in_ready at cycle c: latch in_value and clear the counter. RUN begins at cycle c+1, which is t=0.
- RUN, t = 0..GAMMA-1:
  - in_ready = 0; busy = 1.
  - edge_o[i] is active during cycle t iff v_i != INF and t >= v_i. It is held active to the end of the window (monotone, one transition).
  - pulse_o[i] is active during cycle t iff t < v_i. v_i=0 gives no pulse; INF gives a pulse of width GAMMA.
  - win_start = 1 at t=0; win_done = 1 at t=GAMMA-1.
  - After t=GAMMA-1, go to CLEAR.
- CLEAR, CLR_CYCLES cycles:
  - edge_o and pulse_o = idle level; busy = 1; in_ready = 0.
  - Then go to IDLE.
- Throughput: minimum accept-to-accept spacing is GAMMA+CLR_CYCLES+1 cycles (19 at defaults).
  - in_valid held high during RUN/CLEAR is not accepted.
  - The latched vector is immune to in_value changes after acceptance.
- Counter width is clog2(GAMMA)+1. It does not wrap within a window; it is reset on acceptance.
- Simultaneous events: channels with equal values transition in the same cycle. No channel ordering or skew is permitted.
- Reset mid-window: outputs go to idle asynchronously and the window is abandoned. No win_done is issued.

Test Plan:
- Reset: grst=0 mid-operation -> edge_o=2'b00, pulse_o=2'b00, in_ready=0, busy=0 immediately. Release -> in_ready=1 one cycle later.
- in_value {b=7,a=3} (FALLING=0):
  - Accept at cycle c -> win_start at c+1; edge_o[0] rises at t=3, edge_o[1] rises at t=7.
  - pulse_o[0] high t=0..2, pulse_o[1] high t=0..6; win_done at t=15.
  - edge_o fed to min gives y rising at t=3.
- {b=15(INF), a=0} -> edge_o[0] high from t=0, edge_o[1] never rises; pulse_o[0] never high, pulse_o[1] high t=0..15.
- FALLING=1 with {7,3} -> outputs idle high; edge_o[0] falls at t=3, edge_o[1] falls at t=7; pulse_o[0] low t=0..2, pulse_o[1] low t=0..6; all high again in CLEAR.
- in_valid held high with a changing in_value -> accepts exactly every 19 cycles; each window reflects the value sampled at its accept cycle.
- grst pulsed low at t=5 of a window -> edge_o/pulse_o idle, no win_done. After release, a new {2,2} window gives both edge_o bits rising together at t=2.
